// File: rtl/uart_rx_ctrl_if.sv
// Serial-line and system-side signal bundle for the UART receive controller.
// The master side drives the line and frame configuration; the slave side is the receiver.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start detection, 3-sample majority vote,
// LSB-first deserialisation, optional parity and stop-bit checking.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_ctrl_if.slave bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_q, edge_d;
    logic [5:0]            p_q, p_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [2:0]            samp_q, samp_d;
    logic                  pen_q, pen_d;
    logic                  ptyp_q, ptyp_d;
    logic                  par_flag_q, par_flag_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic [5:0] half;
    logic       last_edge;
    logic       sampled_bit;
    logic       stp_flag;
    logic       enter_start;

    always_comb begin
        state_d      = state_q;
        edge_d       = edge_q;
        p_d          = p_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        samp_d       = samp_q;
        pen_d        = pen_q;
        ptyp_d       = ptyp_q;
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        stp_flag     = 1'b0;
        enter_start  = 1'b0;

        half        = {1'b0, p_q[5:1]};
        last_edge   = (edge_q == p_q - 6'd1);
        sampled_bit = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

        if (state_q != IDLE) begin
            edge_d = last_edge ? '0 : edge_q + 6'd1;
            if (edge_q == half - 6'd1) samp_d[0] = bus.RX_IN;
            if (edge_q == half)        samp_d[1] = bus.RX_IN;
            if (edge_q == half + 6'd1) samp_d[2] = bus.RX_IN;
        end

        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) enter_start = 1'b1;
            end
            START: begin
                if (last_edge) begin
                    state_d = sampled_bit ? IDLE : DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (last_edge) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    if (sampled_bit != ((^shift_q) ^ ptyp_q)) par_flag_d = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    stp_flag     = ~sampled_bit;
                    par_err_d    = par_flag_q;
                    stp_err_d    = stp_flag;
                    data_valid_d = ~par_flag_q & ~stp_flag;
                    if (~par_flag_q & ~stp_flag) p_data_d = shift_q;
                    // A low line on the closing edge is already the next start bit.
                    if (!bus.RX_IN) enter_start = 1'b1;
                    else            state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_start) begin
            state_d    = START;
            edge_d     = '0;
            p_d        = (bus.Prescale == 6'd8 || bus.Prescale == 6'd16 || bus.Prescale == 6'd32)
                         ? bus.Prescale : 6'd8;
            pen_d      = bus.PAR_EN;
            ptyp_d     = bus.PAR_TYP;
            par_flag_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            edge_q       <= '0;
            p_q          <= 6'd8;
            bit_q        <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            samp_q       <= '0;
            pen_q        <= 1'b0;
            ptyp_q       <= 1'b0;
            par_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_q       <= edge_d;
            p_q          <= p_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            samp_q       <= samp_d;
            pen_q        <= pen_d;
            ptyp_q       <= ptyp_d;
            par_flag_q   <= par_flag_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frame senders queue the expected completion pulse,
// a negedge monitor pops and compares whenever any output pulse appears.
module tb_uart_rx_ctrl;
    localparam int DW = 8;

    typedef struct {
        logic            dv;
        logic            pe;
        logic            se;
        logic [DW-1:0]   data;
        int unsigned     cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [DW-1:0] last_good = '0;

    uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: any output pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RST === 1'b1 && (bus.data_valid === 1'b1 || bus.par_err === 1'b1 || bus.stp_err === 1'b1)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: dv=%0b pe=%0b se=%0b P_DATA=%0h at cycle %0d, none required",
                         bus.data_valid, bus.par_err, bus.stp_err, bus.P_DATA, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc,            e.cyc);
                check("data_valid",  bus.data_valid, e.dv);
                check("par_err",     bus.par_err,    e.pe);
                check("stp_err",     bus.stp_err,    e.se);
                check("P_DATA",      bus.P_DATA,     e.data);
            end
        end
    end

    // Sends one frame starting in the current cycle (T0); config is scrambled mid-frame
    // to show it is latched at the start. glitch_bit >= 0 pulls one data bit low for
    // the single cycle at edge P/2.
    task automatic send_frame(input int p, input logic [5:0] cfg_p, input logic [DW-1:0] d,
                              input logic pen, input logic ptyp, input logic bad_par,
                              input logic stop_bit, input int glitch_bit);
        logic frame[$];
        exp_t e;
        frame.push_back(1'b0);
        for (int i = 0; i < DW; i++) frame.push_back(d[i]);
        if (pen) frame.push_back((^d) ^ ptyp ^ bad_par);
        frame.push_back(stop_bit);

        e.pe  = pen & bad_par;
        e.se  = ~stop_bit;
        e.dv  = ~e.pe & ~e.se;
        if (e.dv) last_good = d;
        e.data = last_good;
        e.cyc  = cyc + 1 + p * frame.size();
        sb.push_back(e);

        bus.Prescale = cfg_p;
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        for (int k = 0; k < frame.size(); k++) begin
            for (int j = 0; j < p; j++) begin
                if (k == 1 && j == 0) begin
                    bus.Prescale = (p == 8) ? 6'd16 : 6'd8;
                    bus.PAR_EN   = ~pen;
                    bus.PAR_TYP  = ~ptyp;
                end
                bus.RX_IN = (glitch_bit >= 0 && k == glitch_bit + 1 && j == 1 + p / 2) ? 1'b0 : frame[k];
                tick(1);
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    initial begin
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        #2 RST = 1'b0;
        tick(3);
        check("rst_P_DATA",     bus.P_DATA,     8'h00);
        check("rst_data_valid", bus.data_valid, 1'b0);
        check("rst_par_err",    bus.par_err,    1'b0);
        check("rst_stp_err",    bus.stp_err,    1'b0);
        RST = 1'b1;
        tick(5);

        // P=8, no parity, 0xA5: pulse at T0+81.
        send_frame(8, 6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        tick(6);

        // Start-bit glitch: 3 low cycles, back to IDLE by T0+9, where the next frame begins.
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        tick(3);
        bus.RX_IN = 1'b1;
        tick(6);
        check("glitch_P_DATA_held", bus.P_DATA, 8'hA5);

        // P=8, 0x81 with stop bit 0: stp_err at T0+81, P_DATA keeps 0xA5.
        send_frame(8, 6'd8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        tick(8);

        // P=16, even parity, 0x3C with wrong parity bit: par_err at T0+177.
        send_frame(16, 6'd16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        tick(6);

        // P=32, odd parity, back-to-back 0x55 then 0x0F.
        send_frame(32, 6'd32, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        send_frame(32, 6'd32, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        tick(6);

        // P=32, one-cycle low glitch mid data-1 bit 0 is outvoted.
        send_frame(32, 6'd32, 8'h3B, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        tick(6);

        // Illegal Prescale behaves as 8.
        send_frame(8, 6'd12, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        tick(6);

        // P=16, reset asserted during DATA: frame discarded, P_DATA cleared.
        bus.Prescale = 6'd16;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        tick(16);
        bus.RX_IN = 1'b1;
        tick(48);
        RST = 1'b0;
        tick(3);
        check("midrst_P_DATA",     bus.P_DATA,     8'h00);
        check("midrst_data_valid", bus.data_valid, 1'b0);
        RST = 1'b1;
        last_good = '0;
        tick(200);
        check("midrst_no_late_pulse_P_DATA", bus.P_DATA, 8'h00);
        send_frame(16, 6'd16, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        tick(20);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller; the receive-side counterpart of the UART transmit path.
- Runs on an oversampled clock (CLK = Prescale × baud) and detects start bits on RX_IN.
- Majority-votes three samples per bit and deserialises LSB-first data.
- Checks optional parity and the stop bit, then reports a received byte or error flags to the system controller.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
CLK  in  1  oversampling clock, Prescale × baud rate.
RST  in  1  asynchronous, active-low reset.
RX_IN  in  1  serial line, idle high; already synchronised upstream.
Prescale  in  6  oversampling ratio; legal values 8, 16, 32.
PAR_EN  in  1  1 = frame carries a parity bit.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
P_DATA  out  DATA_WIDTH  last correctly received byte.
data_valid  out  1  one-cycle pulse: P_DATA updated with a good frame.
par_err  out  1  one-cycle pulse: parity mismatch in the completed frame.
stp_err  out  1  one-cycle pulse: stop bit sampled 0 in the completed frame.

Behaviour:
- Reset (asynchronous, RST low) forces:
  - state IDLE; edge_cnt and bit_cnt = 0; shift register = 0.
  - P_DATA = 0; data_valid, par_err, stp_err = 0.
  - Applies mid-frame too; the frame in progress is discarded and no pulse is emitted.
- Configuration latch:
  - Prescale, PAR_EN and PAR_TYP are captured on the IDLE->START transition and held for the whole frame.
  - Changes mid-frame take effect from the next frame.
  - An illegal Prescale value is treated as 8.
- edge_cnt:
  - Counts 0..P-1 within each bit period and wraps to 0 at P-1.
  - Held at 0 in IDLE.
- bit_cnt:
  - Counts data bits 0..DATA_WIDTH-1.
  - Increments on each edge_cnt wrap while in DATA.
- Sampling:
  - RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1.
  - sampled_bit = majority of those 3 samples; valid from edge_cnt = P/2+2.
  - All per-bit decisions are made at edge_cnt = P-1.
- State machine:
  - IDLE: RX_IN = 0 -> START (the detect cycle is not counted); otherwise stay in IDLE.
  - START:
    - At P-1, sampled_bit = 0 -> DATA.
    - At P-1, sampled_bit = 1 -> IDLE (glitch): no flags, no pulse.
  - DATA:
    - At each P-1, shift sampled_bit in LSB-first; the first received bit lands in P_DATA[0].
    - After bit DATA_WIDTH-1 -> PARITY if PAR_EN, else STOP.
  - PARITY:
    - At P-1, compare sampled_bit with the expected bit.
    - Expected bit = XOR of the data bits for even parity; its inverse for odd parity.
    - Mismatch sets internal par_flag; then -> STOP.
  - STOP:
    - At P-1, sampled_bit = 0 sets stp_flag.
    - Frame completes: RX_IN = 0 in that cycle -> START (back-to-back frame, config re-latched); otherwise -> IDLE.
- Completion (registered, visible in the cycle after the stop-bit P-1 edge):
  - No errors: data_valid = 1 and P_DATA = shift register.
  - Any error: data_valid = 0, P_DATA holds its previous value; par_err and/or stp_err = 1 per flag.
  - All three outputs return to 0 the following cycle.
  - Internal flags clear on entry to START.
- Latency: with T0 the IDLE cycle where RX_IN is seen low, the completion pulse is at T0 + 1 + P×(DATA_WIDTH + 2 + PAR_EN).
- Simultaneous events: parity and stop errors in the same frame assert par_err and stp_err in the same cycle.

Test Plan:
- P=8, PAR_EN=0, send 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop 1) -> data_valid pulse at T0+81, P_DATA=0xA5, par_err=stp_err=0.
- P=8, RX_IN low for 3 cycles, then high -> returns to IDLE at T0+9; no output pulse; P_DATA unchanged.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 1 (correct is 0) -> par_err pulse at T0+177, data_valid=0, P_DATA keeps its old value.
- P=8, PAR_EN=0, send 0x81 with stop bit 0 -> stp_err pulse at T0+81, data_valid=0; line then held high -> IDLE.
- P=32, PAR_EN=1, PAR_TYP=1:
  - Send 0x55 then 0x0F back-to-back, with the second start bit immediately after the first stop bit.
  - Expect two data_valid pulses, P_DATA=0x55 then 0x0F, no errors.
  - Separately, inject a 1-cycle low glitch at edge P/2 of a data-1 bit -> byte still correct (majority vote).
- P=16, assert RST mid-DATA, release, send 0xC3 -> no pulse from the aborted frame; the next frame yields P_DATA=0xC3, data_valid=1.
